// File: rtl/audio_sample_sched.sv
// Audio sample scheduler: divisor-driven tick pushes in_port into a sample FIFO
// that is drained over Avalon-MM. Define AUDIO_SAMPLE_SCHED_IRQ_EN for the threshold irq.
module audio_sample_sched #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [15:0] in_port,
    output logic [31:0] readdata
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_DIVISOR = 2'd3
    } reg_addr_e;

    reg_addr_e             reg_sel;
    logic                  enable;
    logic                  overflow;
    logic [DIV_WIDTH-1:0]  divisor;
    logic [DIV_WIDTH-1:0]  tick_cnt;
    logic [DIV_WIDTH-1:0]  cnt_next;
    logic [DIV_WIDTH-1:0]  div_eff;
    logic [15:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [LW-1:0]         level_next;
    logic [31:0]           status_word;
    logic [31:0]           rd_word;

    logic tick;
    logic ctrl_wr;
    logic div_wr;
    logic data_rd;
    logic flush;
    logic clr_ovf;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic ovf_set;
    logic unused_wdata;

`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
    logic [6:0]            threshold;
`endif

    assign unused_wdata = ^writedata;

    always_comb begin
        reg_sel = reg_addr_e'(address);
    end

    always_comb begin
        div_eff    = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
        tick       = enable && (tick_cnt == div_eff - DIV_WIDTH'(1));
        ctrl_wr    = write && (reg_sel == REG_CONTROL);
        div_wr     = write && (reg_sel == REG_DIVISOR);
        data_rd    = read && (reg_sel == REG_DATA);
        flush      = ctrl_wr && writedata[2];
        clr_ovf    = ctrl_wr && writedata[1];
        fifo_empty = (level == '0);
        fifo_full  = (level == LW'(FIFO_DEPTH));
        pop        = data_rd && !fifo_empty;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts the tick
        push       = tick && !flush && (!fifo_full || pop);
        ovf_set    = tick && !flush && fifo_full && !pop;
    end

    always_comb begin
        cnt_next = tick_cnt + DIV_WIDTH'(1);
        if (div_wr || !enable || tick) begin
            cnt_next = '0;
        end
    end

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_comb begin
        status_word        = '0;
        status_word[0]     = enable;
        status_word[1]     = overflow;
        status_word[2]     = fifo_full;
        status_word[3]     = fifo_empty;
        status_word[14:8]  = 7'(level);
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
        status_word[22:16] = threshold;
`endif
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_DATA:    rd_word = pop ? {16'b0, mem[rd_ptr]} : '0;
            REG_STATUS:  rd_word = status_word;
            REG_CONTROL: rd_word = {31'b0, enable};
            REG_DIVISOR: rd_word = 32'(divisor);
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_port;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
            divisor  <= DIV_WIDTH'(1);
            tick_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            readdata <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= writedata[0];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (div_wr) begin
                divisor <= writedata[DIV_WIDTH-1:0];
            end
            tick_cnt <= cnt_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                level <= level_next;
            end
            if (read) begin
                readdata <= rd_word;
            end
        end
    end

`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            threshold <= '0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                threshold <= writedata[22:16];
            end
            irq <= enable && (((threshold != '0) && (7'(level) >= threshold)) || overflow);
        end
    end
`endif

endmodule

// File: tb/tb_audio_sample_sched.sv
// Self-checking bench for audio_sample_sched: directed scenarios plus randomized
// register traffic checked against a queue-based model of the scheduler.
module tb_audio_sample_sched;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] readdata;
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] in_val;

    // reference model state
    logic [15:0] mq[$];
    bit          m_en;
    bit          m_ovf;
    int unsigned m_div;
    int unsigned m_cnt;
    logic [31:0] m_rd;
    logic [6:0]  m_thr;
    bit          m_irq;

    always #5 clk = ~clk;

    audio_sample_sched #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata)
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    function automatic void model_reset();
        mq.delete();
        m_en  = 0;
        m_ovf = 0;
        m_div = 1;
        m_cnt = 0;
        m_rd  = '0;
        m_thr = '0;
        m_irq = 0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = m_en;
        s[1]     = m_ovf;
        s[2]     = (mq.size() == DEPTH);
        s[3]     = (mq.size() == 0);
        s[14:8]  = 7'(mq.size());
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
        s[22:16] = m_thr;
`endif
        return s;
    endfunction

    // One clock of the scheduler's rules applied to the model state.
    function automatic void model_step(input logic [1:0] a, input logic r, input logic w,
                                       input logic [31:0] wd, input logic [15:0] ip);
        int unsigned period;
        bit tick, ctrl_w, div_w, flush, pop, full, ovf_set, irq_next;
        period   = (m_div == 0) ? 1 : m_div;
        tick     = m_en && (m_cnt == period - 1);
        ctrl_w   = w && (a == 2'd2);
        div_w    = w && (a == 2'd3);
        flush    = ctrl_w && wd[2];
        pop      = r && (a == 2'd0) && (mq.size() != 0);
        full     = (mq.size() == DEPTH);
        ovf_set  = tick && !flush && full && !pop;
        irq_next = m_en && (((m_thr != 0) && (mq.size() >= int'(m_thr))) || m_ovf);
        if (r) begin
            case (a)
                2'd0:    m_rd = pop ? {16'b0, mq[0]} : 32'h0;
                2'd1:    m_rd = m_status();
                2'd2:    m_rd = {31'b0, m_en};
                default: m_rd = m_div;
            endcase
        end
        if (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (tick && mq.size() < DEPTH) mq.push_back(ip);
        if (ctrl_w && wd[1]) m_ovf = 0;
        if (ovf_set) m_ovf = 1;
        if (div_w || !m_en || tick) m_cnt = 0;
        else m_cnt++;
        if (ctrl_w) begin
            m_en  = wd[0];
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
            m_thr = wd[22:16];
`endif
        end
        if (div_w) m_div = wd[15:0];
        m_irq = irq_next;
    endfunction

    task automatic step(input logic [1:0] a, input logic r, input logic w, input logic [31:0] wd);
        @(negedge clk);
        address   = a;
        read      = r;
        write     = w;
        writedata = wd;
        in_port   = in_val;
        model_step(a, r, w, wd, in_val);
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        step(a, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        step(a, 1'b0, 1'b1, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; address = 2'd0; read = 0; write = 0; writedata = '0; in_port = '0; in_val = '0;
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
        release_reset();
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0008) begin errors++; $display("FAIL reset_status: got %h expected %h", readdata, 32'h8); end
        rd(2'd3);
        checks++;
        if (readdata !== 32'h0000_0001) begin errors++; $display("FAIL reset_divisor: got %h expected %h", readdata, 32'h1); end
        rd(2'd2);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL reset_control: got %h expected %h", readdata, 32'h0); end
    endtask

    task automatic test_basic_tick();
        wr(2'd3, 32'd4);
        wr(2'd2, 32'h1);
        in_val = 16'h1234;
        idle(4);
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0101) begin errors++; $display("FAIL basic_level: got %h expected %h", readdata, 32'h101); end
        rd(2'd0);
        checks++;
        if (readdata !== 32'h0000_1234) begin errors++; $display("FAIL basic_data: got %h expected %h", readdata, 32'h1234); end
        wr(2'd2, 32'h4);
    endtask

    task automatic test_fill_overflow();
        wr(2'd3, 32'd0);
        wr(2'd2, 32'h1);
        for (int i = 0; i < 8; i++) begin
            in_val = 16'(16'hA000 + i);
            idle(1);
        end
        in_val = 16'hAFFF;
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0805) begin errors++; $display("FAIL fill_full: got %h expected %h", readdata, 32'h805); end
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0807) begin errors++; $display("FAIL fill_overflow: got %h expected %h", readdata, 32'h807); end
    endtask

    task automatic test_pop_full_tick();
        wr(2'd2, 32'h0);
        wr(2'd2, 32'h2);
        wr(2'd2, 32'h1);
        in_val = 16'hB000;
        rd(2'd0);
        checks++;
        if (readdata !== 32'h0000_A000) begin errors++; $display("FAIL popfull_data: got %h expected %h", readdata, 32'hA000); end
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0805) begin errors++; $display("FAIL popfull_status: got %h expected %h", readdata, 32'h805); end
        wr(2'd2, 32'h0);
    endtask

    task automatic test_empty_read();
        wr(2'd2, 32'h6);
        rd(2'd0);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL empty_data: got %h expected %h", readdata, 32'h0); end
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0008) begin errors++; $display("FAIL empty_status: got %h expected %h", readdata, 32'h8); end
    endtask

    task automatic test_flush_and_reset();
        wr(2'd3, 32'd1);
        wr(2'd2, 32'h1);
        idle(5);
        checks++;
        if (mq.size() != 5) begin errors++; $display("FAIL flush_setup: model level %0d expected 5", mq.size()); end
        wr(2'd2, 32'h7);
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0009) begin errors++; $display("FAIL flush_status: got %h expected %h", readdata, 32'h9); end
        idle(3);
        assert_reset();
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL midreset_readdata: got %h expected %h", readdata, 32'h0); end
        release_reset();
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0008) begin errors++; $display("FAIL midreset_status: got %h expected %h", readdata, 32'h8); end
        wr(2'd3, 32'd3);
        wr(2'd2, 32'h1);
        idle(2);
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0009) begin errors++; $display("FAIL reenable_early: got %h expected %h", readdata, 32'h9); end
        rd(2'd1);
        checks++;
        if (readdata !== 32'h0000_0101) begin errors++; $display("FAIL reenable_tick: got %h expected %h", readdata, 32'h101); end
        wr(2'd2, 32'h4);
    endtask

`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
    task automatic test_irq();
        int guard;
        wr(2'd3, 32'd2);
        wr(2'd2, (32'd3 << 16) | 32'h1);
        guard = 0;
        while (mq.size() < 3 && guard < 20) begin
            idle(1);
            guard++;
        end
        checks++;
        if (guard >= 20) begin errors++; $display("FAIL irq_fill_timeout: level %0d expected 3", mq.size()); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
        idle(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
        guard = 0;
        while (mq.size() != 2 && guard < 20) begin
            rd(2'd0);
            guard++;
        end
        checks++;
        if (guard >= 20) begin errors++; $display("FAIL irq_drain_timeout: level %0d expected 2", mq.size()); end
        idle(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", irq); end
        wr(2'd2, 32'h4);
    endtask
`endif

    task automatic test_random();
        logic [31:0] wd;
        int unsigned op;
        for (int n = 0; n < 3000; n++) begin
            op     = $urandom_range(0, 299);
            in_val = 16'($urandom);
            if (op == 0) begin
                assert_reset();
                checks++;
                if (readdata !== 32'h0) begin errors++; $display("FAIL rand_reset: cycle %0d got %h expected 0", n, readdata); end
                release_reset();
            end else if (op < 90) begin
                rd(2'd0);
            end else if (op < 135) begin
                rd(2'($urandom_range(1, 3)));
            end else if (op < 165) begin
                wd        = $urandom;
                wd[0]     = ($urandom_range(0, 9) != 0);
                wd[1]     = ($urandom_range(0, 3) == 0);
                wd[2]     = ($urandom_range(0, 15) == 0);
                wd[22:16] = 7'($urandom_range(0, 9));
                wr(2'd2, wd);
            end else if (op < 175) begin
                wd       = $urandom;
                wd[15:0] = 16'($urandom_range(0, 5));
                wr(2'd3, wd);
            end else if (op < 180) begin
                wr(2'($urandom_range(0, 1)), $urandom);
            end else begin
                idle(1);
            end
            checks++;
            if (readdata !== m_rd) begin errors++; $display("FAIL rand_readdata: cycle %0d got %h expected %h", n, readdata, m_rd); end
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
            checks++;
            if (irq !== m_irq) begin errors++; $display("FAIL rand_irq: cycle %0d got %b expected %b", n, irq, m_irq); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_tick();
        test_fill_overflow();
        test_pop_full_tick();
        test_empty_read();
        test_flush_and_reset();
`ifdef AUDIO_SAMPLE_SCHED_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
